// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, IO window layout and RAM FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [23:0] IO_BASE_HI    = 24'hFFFFFF;
  localparam logic [2:0]  GPIO_DATA_OFS = 3'd0;
  localparam logic [2:0]  GPIO_DIR_OFS  = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ram_state_t;

  // Pick the addressed little-endian lane and sign/zero extend it to a full word.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic zext);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{24{~zext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_extend = {{16{~zext & shifted[15]}}, shifted[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO channels: output and direction registers, 2-flop input
// synchronisers and the combinational read mux for the IO window.
module gpio_bank
  import mem_pkg::*;
#(
  parameter int GPIO_CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [7:0]                offset,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic [GPIO_CHANNELS*32-1:0] gpio_out,
  output logic [GPIO_CHANNELS*32-1:0] gpio_oe,
  input  logic [GPIO_CHANNELS*32-1:0] gpio_in
);

  logic [GPIO_CHANNELS*32-1:0] sync_q1;
  logic [GPIO_CHANNELS*32-1:0] sync_q2;
  logic [4:0] ch;
  logic       is_data;
  logic       is_dir;

  assign ch      = offset[7:3];
  assign is_data = (offset[2:0] == GPIO_DATA_OFS);
  assign is_dir  = (offset[2:0] == GPIO_DIR_OFS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      sync_q1  <= '0;
      sync_q2  <= '0;
    end else begin
      sync_q1 <= gpio_in;
      sync_q2 <= sync_q1;
      for (int n = 0; n < GPIO_CHANNELS; n++) begin
        if (wr_en && ch == 5'(n)) begin
          if (is_data) gpio_out[n*32 +: 32] <= wdata;
          if (is_dir)  gpio_oe[n*32 +: 32]  <= wdata;
        end
      end
    end
  end

  // Pins driven by us read back our own output value; inputs read the synchronised pin.
  always_comb begin
    rdata = '0;
    for (int n = 0; n < GPIO_CHANNELS; n++) begin
      if (ch == 5'(n)) begin
        if (is_data)
          rdata = (sync_q2[n*32 +: 32] & ~gpio_oe[n*32 +: 32]) |
                  (gpio_out[n*32 +: 32] & gpio_oe[n*32 +: 32]);
        else if (is_dir)
          rdata = gpio_oe[n*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/mem_stage_io.sv
// MIPS MEM stage: load/store lane steering, req/ack RAM port with bus-error timeout,
// memory-mapped GPIO bank and the MEM/WB pipeline register.
module mem_stage_io
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int REGS_DEPTH    = 5,
  parameter int GPIO_CHANNELS = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       alu_data_mem,
  input  logic                        reg_d_we_mem,
  input  logic [REGS_DEPTH-1:0]       reg_d_addr_mem,
  input  logic                        reg_d_data_sel_mem,
  input  logic [DATA_WIDTH-1:0]       reg_t_data_mem,
  input  logic                        mem_rd_mem,
  input  logic                        mem_wr_mem,
  input  logic [1:0]                  mem_size_mem,
  input  logic                        mem_unsigned_mem,
  output logic                        stall_mem,
  output logic [DATA_WIDTH-1:0]       alu_data_wb,
  output logic [DATA_WIDTH-1:0]       mem_data_wb,
  output logic                        reg_d_we_wb,
  output logic [REGS_DEPTH-1:0]       reg_d_addr_wb,
  output logic                        reg_d_data_sel_wb,
  output logic                        misalign_wb,
  output logic                        bus_err_wb,
  output logic                        ram_req,
  output logic [3:0]                  ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_wdata,
  input  logic [DATA_WIDTH-1:0]       ram_rdata,
  input  logic                        ram_ack,
  output logic [GPIO_CHANNELS*32-1:0] gpio_out,
  output logic [GPIO_CHANNELS*32-1:0] gpio_oe,
  input  logic [GPIO_CHANNELS*32-1:0] gpio_in
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic       access, is_io, misalign, ram_access, io_access, load_ok, abort;
  logic [1:0] lane;
  logic [3:0] we_mask;
  logic [31:0] io_rdata;
  ram_state_t state, state_next;
  logic [7:0] cnt, cnt_next;

  assign lane       = alu_data_mem[1:0];
  assign access     = mem_rd_mem | mem_wr_mem;
  assign is_io      = (alu_data_mem[31:8] == IO_BASE_HI);
  assign ram_access = access & ~is_io & ~misalign;
  assign io_access  = access & is_io & ~misalign;
  assign ram_addr   = alu_data_mem[ADDR_WIDTH+1:2];

  always_comb begin
    misalign = 1'b0;
    if (access) begin
      if (is_io) misalign = (mem_size_mem != SZ_WORD);
      else begin
        case (mem_size_mem)
          SZ_BYTE: misalign = 1'b0;
          SZ_HALF: misalign = lane[0];
          default: misalign = (lane != 2'b00);
        endcase
      end
    end
  end

  always_comb begin
    case (mem_size_mem)
      SZ_BYTE: begin
        ram_wdata = {4{reg_t_data_mem[7:0]}};
        we_mask   = 4'b0001 << lane;
      end
      SZ_HALF: begin
        ram_wdata = {2{reg_t_data_mem[15:0]}};
        we_mask   = 4'b0011 << lane;
      end
      default: begin
        ram_wdata = reg_t_data_mem;
        we_mask   = 4'hF;
      end
    endcase
  end

  assign ram_we = (ram_req & mem_wr_mem) ? we_mask : 4'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (ram_access && !ram_ack) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (ram_ack || cnt == TIMEOUT_CNT) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are gated by rst so an asynchronous reset mid-WAIT drops the request at once.
  always_comb begin
    ram_req   = 1'b0;
    stall_mem = 1'b0;
    abort     = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          ram_req   = ram_access;
          stall_mem = ram_access & ~ram_ack;
        end
        ST_WAIT: begin
          ram_req   = 1'b1;
          stall_mem = ~ram_ack & (cnt != TIMEOUT_CNT);
          abort     = ~ram_ack & (cnt == TIMEOUT_CNT);
        end
        default: ;
      endcase
    end
  end

  gpio_bank #(.GPIO_CHANNELS(GPIO_CHANNELS)) u_gpio (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (io_access & mem_wr_mem),
    .offset   (alu_data_mem[7:0]),
    .wdata    (reg_t_data_mem),
    .rdata    (io_rdata),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .gpio_in  (gpio_in)
  );

  assign load_ok = mem_rd_mem & ~misalign & (is_io | ram_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_data_wb       <= '0;
      mem_data_wb       <= '0;
      reg_d_we_wb       <= 1'b0;
      reg_d_addr_wb     <= '0;
      reg_d_data_sel_wb <= 1'b0;
      misalign_wb       <= 1'b0;
      bus_err_wb        <= 1'b0;
    end else if (stall_mem) begin
      reg_d_we_wb <= 1'b0;
      misalign_wb <= 1'b0;
      bus_err_wb  <= 1'b0;
    end else begin
      alu_data_wb       <= alu_data_mem;
      reg_d_addr_wb     <= reg_d_addr_mem;
      reg_d_data_sel_wb <= reg_d_data_sel_mem;
      reg_d_we_wb       <= reg_d_we_mem & ~misalign & ~abort;
      misalign_wb       <= misalign;
      bus_err_wb        <= abort;
      mem_data_wb       <= load_ok ? load_extend(is_io ? io_rdata : ram_rdata, lane,
                                                 mem_size_mem, mem_unsigned_mem) : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_io.sv
// Bench for mem_stage_io: directed steps then random traffic against a byte-level RAM
// image and a per-channel GPIO register model.
module tb_mem_stage_io;

  localparam int AW = 9;
  localparam int RD = 5;
  localparam int CH = 4;
  localparam int TO = 15;
  localparam int RAM_BYTES = (1 << AW) * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       alu_data_mem;
  logic              reg_d_we_mem;
  logic [RD-1:0]     reg_d_addr_mem;
  logic              reg_d_data_sel_mem;
  logic [31:0]       reg_t_data_mem;
  logic              mem_rd_mem, mem_wr_mem;
  logic [1:0]        mem_size_mem;
  logic              mem_unsigned_mem;
  logic              stall_mem;
  logic [31:0]       alu_data_wb, mem_data_wb;
  logic              reg_d_we_wb;
  logic [RD-1:0]     reg_d_addr_wb;
  logic              reg_d_data_sel_wb, misalign_wb, bus_err_wb;
  logic              ram_req;
  logic [3:0]        ram_we;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              ram_ack;
  logic [CH*32-1:0]  gpio_out, gpio_oe, gpio_in;

  mem_stage_io #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .REGS_DEPTH(RD),
                 .GPIO_CHANNELS(CH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .alu_data_mem(alu_data_mem), .reg_d_we_mem(reg_d_we_mem),
    .reg_d_addr_mem(reg_d_addr_mem), .reg_d_data_sel_mem(reg_d_data_sel_mem),
    .reg_t_data_mem(reg_t_data_mem), .mem_rd_mem(mem_rd_mem), .mem_wr_mem(mem_wr_mem),
    .mem_size_mem(mem_size_mem), .mem_unsigned_mem(mem_unsigned_mem), .stall_mem(stall_mem),
    .alu_data_wb(alu_data_wb), .mem_data_wb(mem_data_wb), .reg_d_we_wb(reg_d_we_wb),
    .reg_d_addr_wb(reg_d_addr_wb), .reg_d_data_sel_wb(reg_d_data_sel_wb),
    .misalign_wb(misalign_wb), .bus_err_wb(bus_err_wb), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  ram_m [RAM_BYTES];
  logic [31:0] out_m [CH];
  logic [31:0] oe_m  [CH];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    int b;
    b = int'(addr & 32'h7FC);
    return {ram_m[b+3], ram_m[b+2], ram_m[b+1], ram_m[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int nb, input logic uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(ram_m[int'(addr & 32'h7FF) + i]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] io_read(input logic [31:0] addr);
    int c;
    c = int'(addr[7:0]) / 8;
    if (c >= CH) return '0;
    if (addr[2]) return oe_m[c];
    return (gpio_in[c*32 +: 32] & ~oe_m[c]) | (out_m[c] & oe_m[c]);
  endfunction

  task automatic idle(input int n);
    mem_rd_mem = 1'b0;
    mem_wr_mem = 1'b0;
    ram_ack    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One instruction through MEM; lat is the cycle index at which the RAM acks (large = never).
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] data,
                       input int lat, output int stalls);
    logic we_in, sel_in, io, mis, ram_op, exp_stall, abort;
    logic [RD-1:0] rd_addr;
    logic [3:0] mask;
    logic [31:0] wexp;
    int nb, k;
    we_in   = 1'($urandom_range(0, 1));
    sel_in  = 1'($urandom_range(0, 1));
    rd_addr = RD'($urandom_range(0, 31));
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    io      = (addr[31:8] == 24'hFFFFFF);
    mis     = (rd || wr) && (io ? (size != 2'd2) : ((addr % nb) != 0));
    ram_op  = (rd || wr) && !io && !mis;
    mask    = '0;
    if (wr) for (int i = 0; i < nb; i++) mask[int'(addr[1:0]) + i] = 1'b1;
    for (int j = 0; j < 4; j++) wexp[8*j +: 8] = data[8*(j % nb) +: 8];
    alu_data_mem = addr; reg_d_we_mem = we_in; reg_d_addr_mem = rd_addr;
    reg_d_data_sel_mem = sel_in; reg_t_data_mem = data; mem_rd_mem = rd; mem_wr_mem = wr;
    mem_size_mem = size; mem_unsigned_mem = uns;
    ram_rdata = ram_op ? ram_word(addr) : $urandom;
    k = 0;
    stalls = 0;
    forever begin
      ram_ack = ram_op ? (k == lat) : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_stall = ram_op && (k != lat) && (k < TO);
      check("stall_mem", 32'(stall_mem), 32'(exp_stall));
      check("ram_req", 32'(ram_req), 32'(ram_op));
      check("ram_we", 32'(ram_we), (ram_op && wr) ? 32'(mask) : 32'h0);
      if (ram_op) check("ram_addr", 32'(ram_addr), 32'(addr[AW+1:2]));
      if (ram_op && wr) check("ram_wdata", ram_wdata, wexp);
      @(posedge clk);
      #1;
      if (!exp_stall) break;
      check("bubble_we", 32'(reg_d_we_wb), 32'h0);
      check("bubble_misalign", 32'(misalign_wb), 32'h0);
      check("bubble_bus_err", 32'(bus_err_wb), 32'h0);
      stalls++;
      k++;
    end
    abort = ram_op && (k != lat);
    check("alu_data_wb", alu_data_wb, addr);
    check("reg_d_addr_wb", 32'(reg_d_addr_wb), 32'(rd_addr));
    check("reg_d_data_sel_wb", 32'(reg_d_data_sel_wb), 32'(sel_in));
    check("reg_d_we_wb", 32'(reg_d_we_wb), 32'(we_in && !mis && !abort));
    check("misalign_wb", 32'(misalign_wb), 32'(mis));
    check("bus_err_wb", 32'(bus_err_wb), 32'(abort));
    if (rd && !mis && !abort)
      check("mem_data_wb", mem_data_wb, io ? io_read(addr) : model_load(addr, nb, uns));
    if (wr && !mis && !abort) begin
      if (io) begin
        if (int'(addr[7:0]) / 8 < CH) begin
          if (addr[2]) oe_m[int'(addr[7:0]) / 8] = data;
          else         out_m[int'(addr[7:0]) / 8] = data;
        end
      end else begin
        for (int i = 0; i < nb; i++) ram_m[int'(addr & 32'h7FF) + i] = data[8*i +: 8];
      end
    end
    if (io) begin
      for (int c = 0; c < CH; c++) begin
        check("gpio_out", gpio_out[c*32 +: 32], out_m[c]);
        check("gpio_oe", gpio_oe[c*32 +: 32], oe_m[c]);
      end
    end
    mem_rd_mem = 1'b0;
    mem_wr_mem = 1'b0;
    ram_ack    = 1'b0;
  endtask

  initial begin
    int st, kind, c, nb, lat;
    logic [31:0] a;
    logic [1:0] sz;
    logic rdw;
    rst = 1'b1;
    alu_data_mem = '0; reg_d_we_mem = 1'b0; reg_d_addr_mem = '0; reg_d_data_sel_mem = 1'b0;
    reg_t_data_mem = '0; mem_rd_mem = 1'b0; mem_wr_mem = 1'b0; mem_size_mem = 2'd0;
    mem_unsigned_mem = 1'b0; ram_rdata = '0; ram_ack = 1'b0; gpio_in = '0;
    for (int i = 0; i < RAM_BYTES; i++) ram_m[i] = 8'($urandom);
    for (int i = 0; i < CH; i++) begin out_m[i] = '0; oe_m[i] = '0; end

    // Reset state
    #12;
    check("rst_stall", 32'(stall_mem), 32'h0);
    check("rst_ram_req", 32'(ram_req), 32'h0);
    check("rst_alu_data_wb", alu_data_wb, 32'h0);
    check("rst_mem_data_wb", mem_data_wb, 32'h0);
    check("rst_we_wb", 32'(reg_d_we_wb), 32'h0);
    check("rst_gpio_out", gpio_out[31:0] | gpio_out[CH*32-1:CH*32-32], 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Store byte 0xA5 to 0x13, ack same cycle
    do_op(1'b0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5, 0, st);
    check("sb_stalls", 32'(st), 32'd0);

    // Load half from 0x2 of word 0x80FF1234, ack after 3 cycles, signed then unsigned
    do_op(1'b0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h80FF1234, 0, st);
    do_op(1'b1, 1'b0, 32'h2, 2'd1, 1'b0, 32'h0, 3, st);
    check("lh_stalls", 32'(st), 32'd3);
    check("lh_signed", mem_data_wb, 32'hFFFF80FF);
    do_op(1'b1, 1'b0, 32'h2, 2'd1, 1'b1, 32'h0, 3, st);
    check("lhu_unsigned", mem_data_wb, 32'h000080FF);

    // Misaligned word load
    do_op(1'b1, 1'b0, 32'h5, 2'd2, 1'b0, 32'h0, 0, st);
    check("misalign_flag", 32'(misalign_wb), 32'h1);

    // RAM never acks
    do_op(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1000, st);
    check("timeout_stalls", 32'(st), 32'(TO));
    @(negedge clk);
    check("timeout_req_drop", 32'(ram_req), 32'h0);
    @(posedge clk);
    #1;
    check("bus_err_one_cycle", 32'(bus_err_wb), 32'h0);

    // GPIO channel 2
    do_op(1'b0, 1'b1, 32'hFFFFFF14, 2'd2, 1'b0, 32'hFFFF0000, 0, st);
    do_op(1'b0, 1'b1, 32'hFFFFFF10, 2'd2, 1'b0, 32'h12345678, 0, st);
    gpio_in[64 +: 32] = 32'h0000ABCD;
    idle(2);
    do_op(1'b1, 1'b0, 32'hFFFFFF10, 2'd2, 1'b0, 32'h0, 0, st);
    check("gpio_read_ch2", mem_data_wb, 32'h1234ABCD);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        sz  = 2'($urandom_range(0, 2));
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a   = {1'b0, 31'($urandom)};
        if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
        lat = ($urandom_range(0, 19) == 0) ? 100 : $urandom_range(0, 4);
        rdw = 1'($urandom_range(0, 1));
        do_op(rdw, ~rdw, a, sz, 1'($urandom_range(0, 1)), $urandom, lat, st);
      end else if (kind <= 7) begin
        c   = $urandom_range(0, CH);
        a   = 32'hFFFFFF00 | 32'(c * 8) | ($urandom_range(0, 1) ? 32'h4 : 32'h0);
        sz  = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'd2;
        rdw = 1'($urandom_range(0, 1));
        do_op(rdw, ~rdw, a, sz, 1'b0, $urandom, 0, st);
      end else if (kind == 8) begin
        do_op(1'b0, 1'b0, $urandom, 2'($urandom_range(0, 2)), 1'b0, $urandom, 0, st);
      end else begin
        for (int i = 0; i < CH; i++) gpio_in[i*32 +: 32] = $urandom;
        idle(2);
      end
    end

    // Asynchronous reset while waiting on RAM
    do_op(1'b0, 1'b1, 32'hFFFFFF00, 2'd2, 1'b0, 32'hCAFE0001, 0, st);
    alu_data_mem = 32'h40; mem_rd_mem = 1'b1; mem_size_mem = 2'd2; reg_d_we_mem = 1'b1;
    reg_d_addr_mem = 5'd7; reg_d_data_sel_mem = 1'b1; ram_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_stall", 32'(stall_mem), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ram_req", 32'(ram_req), 32'h0);
    check("mid_rst_stall", 32'(stall_mem), 32'h0);
    check("mid_rst_gpio_out0", gpio_out[31:0], 32'h0);
    check("mid_rst_gpio_oe0", gpio_oe[31:0], 32'h0);
    check("mid_rst_alu_data_wb", alu_data_wb, 32'h0);
    check("mid_rst_mem_data_wb", mem_data_wb, 32'h0);
    check("mid_rst_we_wb", 32'(reg_d_we_wb), 32'h0);
    check("mid_rst_addr_wb", 32'(reg_d_addr_wb), 32'h0);
    check("mid_rst_sel_wb", 32'(reg_d_data_sel_wb), 32'h0);
    check("mid_rst_misalign_wb", 32'(misalign_wb), 32'h0);
    check("mid_rst_bus_err_wb", 32'(bus_err_wb), 32'h0);
    mem_rd_mem = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
